// File: rtl/conv_calc_pkg.sv
// Width helpers and the output saturate/ReLU function shared by the conv2 MAC block.
package conv_calc_pkg;

    function automatic int prod_w(input int data_w, input int wgt_w);
        return data_w + wgt_w;
    endfunction

    function automatic int sum_w(input int p_w, input int taps);
        return p_w + $clog2(taps);
    endfunction

    function automatic int acc_w(input int s_w, input int beats);
        return s_w + $clog2(beats);
    endfunction

    // Clamp to the signed data_w range, then optionally zero negatives.
    function automatic logic signed [63:0] sat_relu(input logic signed [63:0] v,
                                                    input int data_w,
                                                    input bit relu);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] r;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        r  = v;
        if (v > hi) begin
            r = hi;
        end else if (v < lo) begin
            r = lo;
        end
        if (relu && (r < 0)) begin
            r = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/conv_calc_acc_lane.sv
// One output channel: K multipliers, adder tree, cross-beat accumulator and
// rescale/saturate output stage. Stage enables come from the top's flag pipeline.
module conv_mac_lane
    import conv_calc_pkg::*;
#(
    parameter int K       = 25,
    parameter int IN_CH   = 3,
    parameter int DATA_W  = 12,
    parameter int WGT_W   = 4,
    parameter int BIAS_W  = 8,
    parameter int FRAC_SH = 8,
    parameter bit RELU    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s0_en,
    input  logic                  s0_last,
    input  logic                  s1_en,
    input  logic                  s1_last,
    input  logic                  s2_en,
    input  logic                  s2_first,
    input  logic                  s2_last,
    input  logic                  out_en,
    input  logic [K*DATA_W-1:0]   data_in,
    input  logic [K*WGT_W-1:0]    weight_in,
    input  logic [BIAS_W-1:0]     bias_in,
    output logic [DATA_W-1:0]     conv_out
);
    localparam int PROD_W = prod_w(DATA_W, WGT_W);
    localparam int SUM_W  = sum_w(PROD_W, K);
    localparam int ACC_W  = acc_w(SUM_W, IN_CH);

    logic signed [PROD_W-1:0] prod_d [K];
    logic signed [PROD_W-1:0] prod_q [K];
    logic signed [SUM_W-1:0]  sum_d, sum_q;
    logic signed [ACC_W-1:0]  acc_d, acc_q;
    logic signed [BIAS_W-1:0] bias1_q, bias2_q, bias3_q;
    logic        [DATA_W-1:0] conv_d, conv_q;

    genvar gi;
    generate
        for (gi = 0; gi < K; gi++) begin : g_mul
            assign prod_d[gi] = PROD_W'($signed(data_in[gi*DATA_W +: DATA_W]))
                              * PROD_W'($signed(weight_in[gi*WGT_W +: WGT_W]));
        end
    endgenerate

    always_comb begin
        sum_d = '0;
        for (int k = 0; k < K; k++) begin
            sum_d = sum_d + SUM_W'(prod_q[k]);
        end
    end

    assign acc_d = s2_first ? ACC_W'(sum_q) : (acc_q + ACC_W'(sum_q));

    // Floor shift, bias add and clamp are done at 64 bits so nothing can wrap.
    always_comb begin
        conv_d = DATA_W'(sat_relu((64'(acc_q) >>> FRAC_SH) + 64'(bias3_q), DATA_W, RELU));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < K; k++) begin
                prod_q[k] <= '0;
            end
            sum_q   <= '0;
            acc_q   <= '0;
            bias1_q <= '0;
            bias2_q <= '0;
            bias3_q <= '0;
            conv_q  <= '0;
        end else begin
            if (s0_en) begin
                prod_q <= prod_d;
                if (s0_last) begin
                    bias1_q <= bias_in;
                end
            end
            if (s1_en) begin
                sum_q <= sum_d;
                if (s1_last) begin
                    bias2_q <= bias1_q;
                end
            end
            if (s2_en) begin
                acc_q <= acc_d;
                if (s2_last) begin
                    bias3_q <= bias2_q;
                end
            end
            if (out_en) begin
                conv_q <= conv_d;
            end
        end
    end

    assign conv_out = conv_q;

endmodule

// File: rtl/conv_calc_acc.sv
// conv2 multi-channel MAC: beat counter and first/last flag pipeline driving
// OUT_CH parallel lanes; one OUT_CH-wide result every IN_CH beats.
module conv_calc_acc
    import conv_calc_pkg::*;
#(
    parameter int K       = 25,
    parameter int OUT_CH  = 3,
    parameter int IN_CH   = 3,
    parameter int DATA_W  = 12,
    parameter int WGT_W   = 4,
    parameter int BIAS_W  = 8,
    parameter int FRAC_SH = 8,
    parameter bit RELU    = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_in,
    input  logic                         clr,
    input  logic [K*DATA_W-1:0]          data_in,
    input  logic [OUT_CH*K*WGT_W-1:0]    weight_in,
    input  logic [OUT_CH*BIAS_W-1:0]     bias_in,
    output logic [OUT_CH*DATA_W-1:0]     conv_out,
    output logic                         valid_out
);
    localparam int CNT_W = (IN_CH > 1) ? $clog2(IN_CH) : 1;

    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             first, last, beat, out_en;
    logic             v1_q, f1_q, l1_q;
    logic             v2_q, f2_q, l2_q;
    logic             v3_q, l3_q;
    logic             vout_q;

    assign first  = (cnt_q == '0);
    assign last   = (cnt_q == CNT_W'(IN_CH - 1));
    assign beat   = valid_in && !clr;
    assign out_en = v3_q && l3_q && !clr;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (valid_in) begin
            cnt_d = last ? '0 : (cnt_q + CNT_W'(1));
        end
    end

    // Flags ride alongside valid; clr kills every stage, including the one about to emit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            v1_q   <= 1'b0;
            f1_q   <= 1'b0;
            l1_q   <= 1'b0;
            v2_q   <= 1'b0;
            f2_q   <= 1'b0;
            l2_q   <= 1'b0;
            v3_q   <= 1'b0;
            l3_q   <= 1'b0;
            vout_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            v1_q   <= beat;
            f1_q   <= first;
            l1_q   <= last;
            v2_q   <= v1_q && !clr;
            f2_q   <= f1_q;
            l2_q   <= l1_q;
            v3_q   <= v2_q && !clr;
            l3_q   <= l2_q;
            vout_q <= out_en;
        end
    end

    assign valid_out = vout_q;

    genvar gi;
    generate
        for (gi = 0; gi < OUT_CH; gi++) begin : g_lane
            conv_mac_lane #(
                .K       (K),
                .IN_CH   (IN_CH),
                .DATA_W  (DATA_W),
                .WGT_W   (WGT_W),
                .BIAS_W  (BIAS_W),
                .FRAC_SH (FRAC_SH),
                .RELU    (RELU)
            ) u_lane (
                .clk       (clk),
                .rst       (rst),
                .s0_en     (beat),
                .s0_last   (last),
                .s1_en     (v1_q),
                .s1_last   (l1_q),
                .s2_en     (v2_q),
                .s2_first  (f2_q),
                .s2_last   (l2_q),
                .out_en    (out_en),
                .data_in   (data_in),
                .weight_in (weight_in[gi*K*WGT_W +: K*WGT_W]),
                .bias_in   (bias_in[gi*BIAS_W +: BIAS_W]),
                .conv_out  (conv_out[gi*DATA_W +: DATA_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_conv_calc_acc.sv
// Scoreboard bench for conv_calc_acc: directed frames push expected results,
// a negedge monitor pops and checks value and latency on both RELU variants.
module tb_conv_calc_acc;
    localparam int K      = 25;
    localparam int OUT_CH = 3;
    localparam int IN_CH  = 3;
    localparam int DATA_W = 12;
    localparam int WGT_W  = 4;
    localparam int BIAS_W = 8;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      valid_in = 1'b0;
    logic                      clr = 1'b0;
    logic [K*DATA_W-1:0]       data_in = '0;
    logic [OUT_CH*K*WGT_W-1:0] weight_in = '0;
    logic [OUT_CH*BIAS_W-1:0]  bias_in = '0;
    logic [OUT_CH*DATA_W-1:0]  conv_out, conv_out_r;
    logic                      valid_out, valid_out_r;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [OUT_CH*DATA_W-1:0] v;
        logic [OUT_CH*DATA_W-1:0] vr;
        int                       due;
    } exp_t;
    exp_t sb[$];

    // rows: d0, d_rest, w0, w1, w2, b0, b1, b2, e0, e1, e2
    int tbl [5][11] = '{
        '{  256,   256, 1, 1,  1, 0, 0,  0,    75,    75,    75},
        '{  256,   256, 1, 2, -1, 0, 3, -2,    75,   153,   -77},
        '{ 2047,  2047, 7, 7,  7, 0, 0,  0,  2047,  2047,  2047},
        '{-2048, -2048, 7, 7,  7, 0, 0,  0, -2048, -2048, -2048},
        '{   -1,     0, 1, 1,  1, 5, 5,  5,     4,     4,     4}
    };

    conv_calc_acc #(.RELU(1'b0)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .clr(clr),
        .data_in(data_in), .weight_in(weight_in), .bias_in(bias_in),
        .conv_out(conv_out), .valid_out(valid_out)
    );

    conv_calc_acc #(.RELU(1'b1)) dut_relu (
        .clk(clk), .rst(rst), .valid_in(valid_in), .clr(clr),
        .data_in(data_in), .weight_in(weight_in), .bias_in(bias_in),
        .conv_out(conv_out_r), .valid_out(valid_out_r)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [OUT_CH*DATA_W-1:0] pack3(input int a, input int b, input int c);
        logic [OUT_CH*DATA_W-1:0] r;
        r = {c[DATA_W-1:0], b[DATA_W-1:0], a[DATA_W-1:0]};
        return r;
    endfunction

    function automatic int relu_of(input int a);
        return (a < 0) ? 0 : a;
    endfunction

    // Monitor: every valid_out must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && (valid_out || valid_out_r)) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valid: got valid_out=%b/%b, expected none (cycle %0d)",
                         valid_out, valid_out_r, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("latency", 64'(cyc), 64'(e.due));
                check("valid_pair", {63'd0, valid_out && valid_out_r}, 64'd1);
                check("conv_out", 64'(conv_out), 64'(e.v));
                check("conv_out_relu", 64'(conv_out_r), 64'(e.vr));
                $display("[TB] result cycle %0d: conv_out=%h relu=%h expected %h / %h",
                         cyc, conv_out, conv_out_r, e.v, e.vr);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            valid_in = 1'b0;
        end
    endtask

    task automatic drive_beat(input int r, input bit last_b);
        int wv;
        int d0, dr, b0, b1, b2;
        d0 = tbl[r][0]; dr = tbl[r][1];
        b0 = tbl[r][5]; b1 = tbl[r][6]; b2 = tbl[r][7];
        @(posedge clk); #1;
        valid_in = 1'b1;
        clr      = 1'b0;
        for (int k = 0; k < K; k++) begin
            data_in[k*DATA_W +: DATA_W] = (k == 0) ? d0[DATA_W-1:0] : dr[DATA_W-1:0];
        end
        for (int c = 0; c < OUT_CH; c++) begin
            wv = tbl[r][2+c];
            for (int k = 0; k < K; k++) begin
                weight_in[(c*K+k)*WGT_W +: WGT_W] = wv[WGT_W-1:0];
            end
        end
        // Bias only matters on the last beat; scramble it otherwise.
        if (last_b) bias_in = {b2[BIAS_W-1:0], b1[BIAS_W-1:0], b0[BIAS_W-1:0]};
        else        bias_in = 24'($urandom);
    endtask

    task automatic frame(input int r, input int gap, input bit expect_out);
        exp_t e;
        for (int i = 0; i < IN_CH; i++) begin
            drive_beat(r, i == IN_CH - 1);
            if (i == IN_CH - 1 && expect_out) begin
                e.v   = pack3(tbl[r][8], tbl[r][9], tbl[r][10]);
                e.vr  = pack3(relu_of(tbl[r][8]), relu_of(tbl[r][9]), relu_of(tbl[r][10]));
                e.due = cyc + 4;
                sb.push_back(e);
            end
            if (i < IN_CH - 1) idle(gap);
        end
    endtask

    // clr together with a valid beat: the beat must be dropped.
    task automatic do_clr();
        @(posedge clk); #1;
        clr      = 1'b1;
        valid_in = 1'b1;
        @(posedge clk); #1;
        clr      = 1'b0;
        valid_in = 1'b0;
    endtask

    task automatic do_rst();
        @(posedge clk); #3;
        rst = 1'b1;
        @(negedge clk);
        check("rst_valid_out", {62'd0, valid_out, valid_out_r}, 64'd0);
        check("rst_conv_out", 64'(conv_out), 64'd0);
        check("rst_conv_out_relu", 64'(conv_out_r), 64'd0);
        @(posedge clk); #1;
        rst      = 1'b0;
        valid_in = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int gaps [3] = '{0, 1, 5};
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_valid_out", 64'(valid_out), 64'd0);
        check("reset_valid_out_relu", 64'(valid_out_r), 64'd0);
        check("reset_conv_out", 64'(conv_out), 64'd0);
        check("reset_conv_out_relu", 64'(conv_out_r), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // All directed frames at intra- and inter-frame gaps of 0, 1 and 5.
        foreach (gaps[g]) begin
            for (int r = 0; r < 5; r++) begin
                frame(r, gaps[g], 1'b1);
                idle(gaps[g]);
            end
            idle(6);
        end

        // Abort after two beats, then a clean frame.
        drive_beat(1, 1'b0);
        drive_beat(1, 1'b0);
        do_clr();
        frame(0, 0, 1'b1);
        idle(6);

        // clr one cycle after a last beat cancels the in-flight result.
        frame(0, 0, 1'b0);
        do_clr();
        frame(1, 0, 1'b1);
        idle(6);

        // Reset mid-frame.
        drive_beat(2, 1'b0);
        drive_beat(2, 1'b0);
        do_rst();
        frame(0, 0, 1'b1);
        idle(6);

        // Reset while a result is in flight.
        frame(1, 0, 1'b0);
        idle(1);
        do_rst();
        frame(0, 1, 1'b1);
        idle(8);

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
